// File: rtl/modular_addsub_seq_if.sv
// ============================================================================
// Module      : modular_addsub_seq_if
// Description : Request/result bundle for the limb-serial modular add/sub unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface modular_addsub_seq_if #(
   parameter int WIDTH = 256
);
   logic             start;
   logic             mode;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] P;
   logic             busy;
   logic             done_add;
   logic             err;
   logic [WIDTH-1:0] R;

   modport master (
      output start, mode, A, B, P,
      input  busy, done_add, err, R
   );

   modport slave (
      input  start, mode, A, B, P,
      output busy, done_add, err, R
   );
endinterface

`default_nettype wire

// File: rtl/modular_addsub_seq.sv
// ============================================================================
// Module      : modular_addsub_seq
// Description : Limb-serial modular add/subtract: two chained passes, then select.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module modular_addsub_seq #(
   parameter int WIDTH = 256,
   parameter int LIMB  = 64
) (
   input  wire logic           clk,
   input  wire logic           rst,
   modular_addsub_seq_if.slave bus
);
   localparam int c_n  = WIDTH / LIMB;
   localparam int c_cw = (c_n > 1) ? $clog2(c_n) : 1;
   localparam logic [c_cw-1:0] c_last = c_cw'(c_n - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS1 = 2'd1,
      PASS2 = 2'd2,
      FIN   = 2'd3
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a, r_b, r_p, r_t, r_d, r_r;
   logic             r_mode, r_pz, r_c, r_c1;
   logic [c_cw-1:0]  r_cnt;
   logic             r_busy, r_done, r_err;

   logic [31:0]      w_base;
   logic [LIMB-1:0]  w_op_x, w_op_y;
   logic [LIMB:0]    w_sum;
   logic             w_take_d;

   assign w_base = 32'(r_cnt) * 32'(LIMB);

   // One shared limb adder: subtraction is x + ~y with carry-in 1, so the
   // carry-out is the inverted borrow.
   always_comb begin
      w_op_x = r_t[w_base +: LIMB];
      w_op_y = r_mode ? r_p[w_base +: LIMB] : ~r_p[w_base +: LIMB];
      if (r_state == PASS1) begin
         w_op_x = r_a[w_base +: LIMB];
         w_op_y = r_mode ? ~r_b[w_base +: LIMB] : r_b[w_base +: LIMB];
      end
   end

   assign w_sum    = {1'b0, w_op_x} + {1'b0, w_op_y} + {{LIMB{1'b0}}, r_c};
   assign w_take_d = r_mode ? r_c1 : (r_c1 | r_c);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_p     <= '0;
         r_t     <= '0;
         r_d     <= '0;
         r_r     <= '0;
         r_mode  <= 1'b0;
         r_pz    <= 1'b0;
         r_c     <= 1'b0;
         r_c1    <= 1'b0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_a     <= bus.A;
                  r_b     <= bus.B;
                  r_p     <= bus.P;
                  r_mode  <= bus.mode;
                  r_pz    <= (bus.P == '0);
                  r_c     <= bus.mode;
                  r_c1    <= 1'b0;
                  r_cnt   <= '0;
                  r_err   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= PASS1;
               end
            end
            PASS1: begin
               r_t[w_base +: LIMB] <= w_sum[LIMB-1:0];
               if (r_cnt == c_last) begin
                  // c1 is carry-out for add, borrow for subtract
                  r_c1    <= w_sum[LIMB] ^ r_mode;
                  r_c     <= ~r_mode;
                  r_cnt   <= '0;
                  r_state <= PASS2;
               end else begin
                  r_c     <= w_sum[LIMB];
                  r_cnt   <= r_cnt + 1'b1;
               end
            end
            PASS2: begin
               r_d[w_base +: LIMB] <= w_sum[LIMB-1:0];
               r_c                 <= w_sum[LIMB];
               if (r_cnt == c_last) begin
                  r_cnt   <= '0;
                  r_state <= FIN;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
               end
            end
            FIN: begin
               if (r_pz) begin
                  r_r   <= '0;
                  r_err <= 1'b1;
               end else begin
                  r_r   <= w_take_d ? r_d : r_t;
               end
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.busy     = r_busy;
   assign bus.done_add = r_done;
   assign bus.err      = r_err;
   assign bus.R        = r_r;

endmodule

`default_nettype wire

// File: tb/tb_modular_addsub_seq.sv
// ============================================================================
// Module      : tb_modular_addsub_seq
// Description : Directed self-checking bench for modular_addsub_seq (256/64).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_modular_addsub_seq;
   localparam int W = 256;
   localparam logic [W-1:0] c_ones = {W{1'b1}};
   localparam logic [W-1:0] c_b64  = W'(1) << 64;
   localparam logic [W-1:0] c_b128 = W'(1) << 128;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   int   lat;
   int   ndone;

   modular_addsub_seq_if #(.WIDTH(W)) bus ();

   modular_addsub_seq #(.WIDTH(W), .LIMB(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Presents a request for one edge; lat counts edges after the sampling edge.
   task automatic launch(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] p, input string tag);
      @(negedge clk);
      bus.start = 1'b1;
      bus.mode  = m;
      bus.A     = a;
      bus.B     = b;
      bus.P     = p;
      @(posedge clk);
      #1;
      lat = 0;
      check({tag, "_busy"}, W'(bus.busy), W'(1));
      check({tag, "_errclr"}, W'(bus.err), W'(0));
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      while (!bus.done_add && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_lat"}, W'(lat), W'(9));
      check({tag, "_excl"}, W'(bus.busy & bus.done_add), W'(0));
   endtask

   task automatic do_op(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] p, input logic [W-1:0] exp_r,
                        input logic exp_err, input string tag);
      launch(m, a, b, p, tag);
      wait_done(tag);
      check({tag, "_R"}, bus.R, exp_r);
      check({tag, "_err"}, W'(bus.err), W'(exp_err));
   endtask

   task automatic count_done(input int cycles);
      ndone = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (bus.done_add) ndone++;
      end
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      lat       = 0;
      ndone     = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.mode  = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      bus.P     = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", W'(bus.busy), W'(0));
      check("rst_done", W'(bus.done_add), W'(0));
      check("rst_err", W'(bus.err), W'(0));
      check("rst_R", bus.R, '0);
      @(negedge clk);
      rst = 1'b0;

      do_op(1'b0, W'(1), W'(2), W'(3), W'(0), 1'b0, "add_1_2_m3");
      @(posedge clk);
      #1;
      check("done_pulse", W'(bus.done_add), W'(0));

      // back-to-back: each launch lands in the done cycle of the previous op
      do_op(1'b0, W'(5), W'(3), W'(7), W'(1), 1'b0, "add_5_3_m7");
      do_op(1'b1, W'(3), W'(5), W'(7), W'(5), 1'b0, "sub_3_5_m7");
      do_op(1'b1, W'(5), W'(3), W'(7), W'(2), 1'b0, "sub_5_3_m7");

      do_op(1'b0, c_ones - 1, c_ones - 1, c_ones, c_ones - 2, 1'b0, "add_carry_out");
      do_op(1'b0, c_b64 - 1, W'(1), c_b128, c_b64, 1'b0, "add_limb_carry");
      do_op(1'b1, c_b64, W'(1), c_b128, c_b64 - 1, 1'b0, "sub_limb_borrow");

      do_op(1'b0, c_ones, W'(1), W'(0), W'(0), 1'b1, "p_zero");

      // second start 3 cycles in must be ignored
      launch(1'b0, W'(5), W'(3), W'(7), "ign");
      repeat (3) begin
         @(posedge clk);
         #1;
         lat++;
      end
      @(negedge clk);
      bus.start = 1'b1;
      bus.mode  = 1'b1;
      bus.A     = W'(1);
      bus.B     = W'(6);
      bus.P     = W'(11);
      @(posedge clk);
      #1;
      lat++;
      @(negedge clk);
      bus.start = 1'b0;
      bus.A     = c_ones;
      bus.P     = W'(0);
      wait_done("ign");
      check("ign_R", bus.R, W'(1));
      count_done(12);
      check("ign_single_done", W'(ndone), W'(0));

      // asynchronous abort 4 cycles in
      launch(1'b0, W'(4), W'(4), W'(5), "abort");
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_busy", W'(bus.busy), W'(0));
      check("abort_R", bus.R, '0);
      check("abort_done", W'(bus.done_add), W'(0));
      @(negedge clk);
      rst = 1'b0;
      count_done(14);
      check("abort_no_done", W'(ndone), W'(0));
      do_op(1'b0, W'(4), W'(4), W'(5), W'(3), 1'b0, "after_abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/modular_addsub_seq.md
MODULAR_ADDSUB_SEQ -- requirements
Module: modular_addsub_seq

Interface
REQ-001 Parameter WIDTH, default 256, operand/modulus/result width in bits.
REQ-002 Parameter LIMB, default 64, bits processed per cycle; WIDTH SHALL be an integer multiple of LIMB; N = WIDTH/LIMB.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 mode  input  1  0 = modular add, 1 = modular subtract; latched with start.
REQ-007 A  input  WIDTH  first operand; latched with start.
REQ-008 B  input  WIDTH  second operand; latched with start.
REQ-009 P  input  WIDTH  modulus; latched with start.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done_add  output  1  single-cycle completion pulse.
REQ-012 err  output  1  high with done_add when latched P == 0; held until next start is accepted.
REQ-013 R  output  WIDTH  result register; valid from done_add, held until next done_add.

Function
REQ-014 FSM states SHALL be IDLE, PASS1, PASS2, FIN; no other states.
REQ-015 IDLE: start=1 at an edge latches A, B, P, mode, clears err and the limb counter, sets busy=1, enters PASS1.
REQ-016 PASS1: one LIMB-wide limb per edge, LSB limb first: T = A+B (mode 0) or A-B (mode 1), carry/borrow registered between limbs; after N edges, final carry/borrow kept as flag c1; enter PASS2.
REQ-017 PASS2: one limb per edge, LSB first: D = T-P (mode 0) or T+P (mode 1), WIDTH bits, carry/borrow chained; after N edges enter FIN.
REQ-018 FIN (one edge): mode 0: R = D if c1=1 or T >= P (no final borrow in PASS2), else R = T; mode 1: R = D if c1 (borrow) = 1, else R = T; done_add=1, busy=0, next state IDLE.
REQ-019 P == 0: same timing; FIN writes R = 0 and err = 1.
REQ-020 Latency: done_add SHALL be high in the cycle after the (2N+1)th edge following the start-sampling edge (default: 9 cycles); high for exactly one cycle.
REQ-021 start while busy=1 SHALL be ignored; latched operands unaffected by input changes during an operation.
REQ-022 start high in the same cycle done_add is high SHALL be accepted (back-to-back), the FSM being in IDLE then.
REQ-023 Results SHALL be exact for A, B < P; for out-of-range operands R follows REQ-016..018 literally, with no flag.
REQ-024 All intermediate sums SHALL wrap modulo 2^WIDTH apart from the explicit c1 flag.
REQ-025 busy and done_add SHALL never be high together.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, busy=0, done_add=0, err=0, R=0, counter and carry flags 0, regardless of clock.
REQ-027 rst asserted mid-operation SHALL abort it with no done_add; the first start after rst deasserts SHALL run a full-latency operation.

Verification (WIDTH=256, LIMB=64)
REQ-028 mode0, A=1, B=2, P=3 -> done_add 9 cycles after start, R=0, err=0.
REQ-029 mode0, A=5, B=3, P=7 -> R=1; then mode1, A=3, B=5, P=7 -> R=5; then mode1, A=5, B=3 -> R=2.
REQ-030 mode0, A=B=2^256-2, P=2^256-1 (carry-out case) -> R=2^256-3 (FF..FD), err=0.
REQ-031 A=2^256-1, B=1, P=0 -> R=0, err=1 with done_add, same 9-cycle latency; err clears on next accepted start.
REQ-032 start pulsed again 3 cycles into an operation with different operands -> ignored, first result unchanged, single done_add.
REQ-033 rst asserted 4 cycles into an operation -> outputs 0 immediately, no done_add; new start after release -> correct result at full latency.
